// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: synchronised, debounced RUN/STOP and CLEAR buttons feed a
// STOP/RUN/CLEAR FSM whose registered outputs drive the datapath controls.

module stopwatch_btn #(
  parameter int DB_COUNT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int            CW      = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  logic          meta_q;
  logic          sync_q;
  logic          db_lvl_q;
  logic          db_dly_q;
  logic [CW-1:0] cnt_q;

  // Any disagreement shorter than DB_COUNT cycles falls back to a zero count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      db_lvl_q <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= btn_i;
      sync_q   <= meta_q;
      db_dly_q <= db_lvl_q;
      if (sync_q == db_lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        db_lvl_q <= sync_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = db_lvl_q & ~db_dly_q;
endmodule

module stopwatch_cu #(
  parameter int DB_COUNT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_clear,
  output logic       run_stop,
  output logic       clear,
  output logic [1:0] o_state
);
  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   run_press;
  logic   clear_press;

  stopwatch_btn #(.DB_COUNT(DB_COUNT)) u_btn_run (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_run),
    .press_o(run_press)
  );

  stopwatch_btn #(.DB_COUNT(DB_COUNT)) u_btn_clear (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_clear),
    .press_o(clear_press)
  );

  // RUN has priority over CLEAR when both arrive in the same STOP cycle.
  always_comb begin
    state_d = ST_STOP;
    case (state_q)
      ST_STOP: begin
        if (run_press)        state_d = ST_RUN;
        else if (clear_press) state_d = ST_CLEAR;
        else                  state_d = ST_STOP;
      end
      ST_RUN:  state_d = run_press ? ST_STOP : ST_RUN;
      default: state_d = ST_STOP;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STOP;
      run_stop <= 1'b0;
      clear    <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_stop <= (state_d == ST_RUN);
      clear    <= (state_d == ST_CLEAR);
    end
  end

  assign o_state = state_q;
endmodule

// File: tb/tb_stopwatch_cu.sv
// Bench for stopwatch_cu with DB_COUNT=4: directed button sequences, a window-based
// reference model checked every cycle, and hand-computed checkpoints.
module tb_stopwatch_cu;
  localparam int DB = 4;

  logic       clk;
  logic       rst;
  logic       btn_run;
  logic       btn_clear;
  logic       run_stop;
  logic       clear;
  logic [1:0] o_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  stopwatch_cu #(.DB_COUNT(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btn_run),
    .btn_clear(btn_clear),
    .run_stop (run_stop),
    .clear    (clear),
    .o_state  (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a button level flips once the last DB samples seen by the
  // debouncer (raw input delayed two edges) all disagree with it.
  bit m_raw [2][2];
  bit m_win [2][DB];
  bit m_db  [2];
  bit m_dbp [2];
  bit m_btn [2];
  bit m_pr, m_pc, m_samp, m_all;
  int m_state;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_state = 0;
        for (int c = 0; c < 2; c++) begin
          m_db[c] = 0; m_dbp[c] = 0; m_raw[c][0] = 0; m_raw[c][1] = 0;
          for (int i = 0; i < DB; i++) m_win[c][i] = 0;
        end
      end else begin
        m_pr = m_db[0] & ~m_dbp[0];
        m_pc = m_db[1] & ~m_dbp[1];
        case (m_state)
          0:       m_state = m_pr ? 1 : (m_pc ? 2 : 0);
          1:       m_state = m_pr ? 0 : 1;
          default: m_state = 0;
        endcase
        m_btn[0] = btn_run;
        m_btn[1] = btn_clear;
        for (int c = 0; c < 2; c++) begin
          m_dbp[c] = m_db[c];
          m_samp = m_raw[c][1];
          for (int i = DB - 1; i > 0; i--) m_win[c][i] = m_win[c][i-1];
          m_win[c][0] = m_samp;
          m_all = 1;
          for (int i = 0; i < DB; i++) if (m_win[c][i] == m_db[c]) m_all = 0;
          if (m_all) m_db[c] = ~m_db[c];
          m_raw[c][1] = m_raw[c][0];
          m_raw[c][0] = m_btn[c];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("model_run_stop", {31'b0, run_stop}, {31'b0, (m_state == 1)});
        check("model_clear",    {31'b0, clear},    {31'b0, (m_state == 2)});
        check("model_o_state",  {30'b0, o_state},  m_state);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [1:0] st, input logic rs, input logic cl);
    check({name, "_o_state"},  {30'b0, o_state},  {30'b0, st});
    check({name, "_run_stop"}, {31'b0, run_stop}, {31'b0, rs});
    check({name, "_clear"},    {31'b0, clear},    {31'b0, cl});
  endtask

  // Clean single press of btn_run: held long enough to register, then fully released.
  task automatic press_run();
    btn_run = 1'b1;
    tick(8);
    btn_run = 1'b0;
    tick(10);
  endtask

  logic [8:0] bounce;

  initial begin
    btn_run = 1'b0; btn_clear = 1'b0; rst = 1'b1;
    tick(2);
    cmp_en = 1;
    rst = 1'b0;
    chk_out("reset", 2'b00, 1'b0, 1'b0);
    tick(100);
    chk_out("idle100", 2'b00, 1'b0, 1'b0);

    // Held run button: no change through edge 6, RUN at edge 7; second press stops.
    btn_run = 1'b1;
    tick(6);
    chk_out("run_e6", 2'b00, 1'b0, 1'b0);
    tick(1);
    chk_out("run_e7", 2'b01, 1'b1, 1'b0);
    btn_run = 1'b0;
    tick(10);
    btn_run = 1'b1;
    tick(7);
    chk_out("stop_e7", 2'b00, 1'b0, 1'b0);
    btn_run = 1'b0;
    tick(10);

    // Bounce 1,2,3 cycles high with single low gaps never reaches the FSM.
    bounce = 9'b1_0110_1110;
    for (int i = 8; i >= 0; i--) begin
      btn_run = bounce[i];
      tick(1);
    end
    tick(6);
    chk_out("bounce", 2'b00, 1'b0, 1'b0);
    btn_run = 1'b1;
    tick(7);
    chk_out("stable_run", 2'b01, 1'b1, 1'b0);
    btn_run = 1'b0;
    tick(10);
    press_run();
    chk_out("back_stop", 2'b00, 1'b0, 1'b0);

    // CLEAR from STOP: one-cycle pulse, then STOP.
    btn_clear = 1'b1;
    tick(7);
    chk_out("clr_e7", 2'b10, 1'b0, 1'b1);
    tick(1);
    chk_out("clr_e8", 2'b00, 1'b0, 1'b0);
    btn_clear = 1'b0;
    tick(10);

    // CLEAR in RUN is ignored.
    press_run();
    btn_clear = 1'b1;
    tick(10);
    chk_out("clr_in_run", 2'b01, 1'b1, 1'b0);
    btn_clear = 1'b0;
    tick(10);
    press_run();

    // Simultaneous presses in STOP: RUN wins, no clear pulse.
    btn_run = 1'b1; btn_clear = 1'b1;
    tick(7);
    chk_out("both_e7", 2'b01, 1'b1, 1'b0);
    tick(1);
    chk_out("both_e8", 2'b01, 1'b1, 1'b0);
    btn_run = 1'b0; btn_clear = 1'b0;
    tick(10);

    // Long hold in RUN gives exactly one transition.
    btn_run = 1'b1;
    tick(7);
    chk_out("hold_e7", 2'b00, 1'b0, 1'b0);
    tick(43);
    chk_out("hold_e50", 2'b00, 1'b0, 1'b0);
    btn_run = 1'b0;
    tick(10);

    // Async reset mid-debounce from RUN; held button re-debounces into one press.
    press_run();
    btn_run = 1'b1;
    tick(4);
    chk_out("pre_rst", 2'b01, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 2'b00, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk_out("post_rst_e6", 2'b00, 1'b0, 1'b0);
    tick(1);
    chk_out("post_rst_e7", 2'b01, 1'b1, 1'b0);
    tick(30);
    chk_out("post_rst_hold", 2'b01, 1'b1, 1'b0);
    btn_run = 1'b0;
    tick(10);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
